router_switch_allocator: RTL and testbench

Output-port allocator and switch for the 2x2-mesh router. Sits directly downstream of the per-channel route computation: takes the flit and its 2-bit direction code from each input FIFO (X, Y, Local), arbitrates round-robin per output port and moves the winning 40-bit flit into a one-entry output register with valid/ready handshake toward the link or local sink. It sequences and shares the three output ports between the three input channels.

---
 rtl/router_pkg.sv | 31 +++
 rtl/router_switch_allocator_rr_arb3.sv | 38 +++
 rtl/router_switch_allocator.sv | 114 +++++++++++
 tb/tb_router_switch_allocator.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared router definitions: direction codes, port indices and flit widths.
// Also used by the route computation stage.
package router_pkg;

    localparam int FLIT_W = 40;
    localparam int CNT_W  = 16;
    localparam int NPORT  = 3;

    localparam int PORT_X     = 0;
    localparam int PORT_Y     = 1;
    localparam int PORT_LOCAL = 2;

    typedef enum logic [1:0] {
        DIR_NONE  = 2'b00,
        DIR_X     = 2'b01,
        DIR_Y     = 2'b10,
        DIR_LOCAL = 2'b11
    } dir_e;

    typedef struct packed {
        logic              valid;
        logic [1:0]        route;
        logic [FLIT_W-1:0] data;
    } in_req_t;

    // Output port index p is addressed by direction code p+1.
    function automatic logic [1:0] dir_of_port(input int p);
        return 2'(p + 1);
    endfunction

endpackage

// File: rtl/router_switch_allocator_rr_arb3.sv
// Three-way round-robin arbiter. The search starts one past the last winner;
// the pointer only moves when a grant is issued.
module rr_arb3 (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req_i,
    input  logic       en_i,
    output logic [2:0] gnt_o
);

    logic [1:0] ptr_q, ptr_d;
    logic [1:0] idx;
    logic       found;

    always_comb begin
        gnt_o = '0;
        ptr_d = ptr_q;
        idx   = '0;
        found = 1'b0;
        if (en_i) begin
            for (int k = 1; k <= 3; k++) begin
                idx = 2'((32'(ptr_q) + 32'(k)) % 32'd3);
                if (!found && req_i[idx]) begin
                    gnt_o[idx] = 1'b1;
                    ptr_d      = idx;
                    found      = 1'b1;
                end
            end
        end
    end

    // Pointer resets to 2 so input 0 is favoured first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= 2'd2;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/router_switch_allocator.sv
// Switch allocator: per-output round-robin arbitration into one-entry output registers.
// Optional ROUTER_ALLOC_STALL_CNT_EN adds saturating per-output arbitration-loss counters.
module router_switch_allocator
    import router_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        in_valid,
    input  logic [FLIT_W-1:0] in_data_x,
    input  logic [FLIT_W-1:0] in_data_y,
    input  logic [FLIT_W-1:0] in_data_local,
    input  logic [1:0]        in_route_x,
    input  logic [1:0]        in_route_y,
    input  logic [1:0]        in_route_local,
    output logic [2:0]        in_ready,
    output logic [2:0]        out_valid,
    output logic [FLIT_W-1:0] out_data_x,
    output logic [FLIT_W-1:0] out_data_y,
    output logic [FLIT_W-1:0] out_data_local,
    input  logic [2:0]        out_ready,
    output logic              err_route
`ifdef ROUTER_ALLOC_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt_x,
    output logic [CNT_W-1:0]  stall_cnt_y,
    output logic [CNT_W-1:0]  stall_cnt_local
`endif
);

    in_req_t [2:0]              inp;
    logic [2:0][2:0]            req, gnt;   // [output][input]
    logic [2:0]                 load_en, drop;
    logic [2:0]                 out_valid_q, out_valid_d;
    logic [2:0][FLIT_W-1:0]     out_data_q, out_data_d;
    logic                       err_q, err_d;

    assign inp[PORT_X]     = {in_valid[PORT_X],     in_route_x,     in_data_x};
    assign inp[PORT_Y]     = {in_valid[PORT_Y],     in_route_y,     in_data_y};
    assign inp[PORT_LOCAL] = {in_valid[PORT_LOCAL], in_route_local, in_data_local};

    for (genvar o = 0; o < NPORT; o++) begin : g_out
        for (genvar i = 0; i < NPORT; i++) begin : g_req
            assign req[o][i] = inp[i].valid && (inp[i].route == dir_of_port(o));
        end
        // Drain and load may coincide, so a ready consumer keeps the slot free.
        assign load_en[o] = !rst && (!out_valid_q[o] || out_ready[o]);

        rr_arb3 u_arb (
            .clk   (clk),
            .rst   (rst),
            .req_i (req[o]),
            .en_i  (load_en[o]),
            .gnt_o (gnt[o])
        );
    end

    for (genvar i = 0; i < NPORT; i++) begin : g_drop
        assign drop[i] = !rst && inp[i].valid && (inp[i].route == DIR_NONE);
    end

    always_comb begin
        in_ready    = drop;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        for (int o = 0; o < NPORT; o++) begin
            in_ready = in_ready | gnt[o];
            if (|gnt[o]) begin
                out_valid_d[o] = 1'b1;
                for (int i = 0; i < NPORT; i++)
                    if (gnt[o][i]) out_data_d[o] = inp[i].data;
            end else if (out_ready[o]) begin
                out_valid_d[o] = 1'b0;
            end
        end
        err_d = |drop;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= '0;
            out_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            err_q       <= err_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_data_x     = out_data_q[PORT_X];
    assign out_data_y     = out_data_q[PORT_Y];
    assign out_data_local = out_data_q[PORT_LOCAL];
    assign err_route      = err_q;

`ifdef ROUTER_ALLOC_STALL_CNT_EN
    logic [2:0][CNT_W-1:0] stall_q;

    // Any requester left ungranted counts, including backpressure cycles.
    for (genvar o = 0; o < NPORT; o++) begin : g_stall
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                stall_q[o] <= '0;
            else if (|(req[o] & ~gnt[o]) && !(&stall_q[o]))
                stall_q[o] <= stall_q[o] + 1'b1;
        end
    end

    assign stall_cnt_x     = stall_q[PORT_X];
    assign stall_cnt_y     = stall_q[PORT_Y];
    assign stall_cnt_local = stall_q[PORT_LOCAL];
`endif

endmodule

// File: tb/tb_router_switch_allocator.sv
// Self-checking bench for router_switch_allocator: directed scenarios followed by
// random traffic, all checked against a behavioural reference model.
module tb_router_switch_allocator;
    import router_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [2:0]        in_valid = '0;
    logic [FLIT_W-1:0] in_data_x = '0, in_data_y = '0, in_data_local = '0;
    logic [1:0]        in_route_x = '0, in_route_y = '0, in_route_local = '0;
    logic [2:0]        in_ready;
    logic [2:0]        out_valid;
    logic [FLIT_W-1:0] out_data_x, out_data_y, out_data_local;
    logic [2:0]        out_ready = '0;
    logic              err_route;
`ifdef ROUTER_ALLOC_STALL_CNT_EN
    logic [CNT_W-1:0]  stall_cnt_x, stall_cnt_y, stall_cnt_local;
`endif

    always #5 clk = ~clk;

    router_switch_allocator dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .in_data_x(in_data_x), .in_data_y(in_data_y), .in_data_local(in_data_local),
        .in_route_x(in_route_x), .in_route_y(in_route_y), .in_route_local(in_route_local),
        .in_ready(in_ready), .out_valid(out_valid),
        .out_data_x(out_data_x), .out_data_y(out_data_y), .out_data_local(out_data_local),
        .out_ready(out_ready), .err_route(err_route)
`ifdef ROUTER_ALLOC_STALL_CNT_EN
        , .stall_cnt_x(stall_cnt_x), .stall_cnt_y(stall_cnt_y), .stall_cnt_local(stall_cnt_local)
`endif
    );

    int vec  = 0;
    int miss = 0;

    // Reference model state
    bit          m_ov[3];
    logic [39:0] m_od[3];
    int          m_ptr[3];
    bit          m_err;
    int          m_stall[3];
    int          m_win[3];
    bit          m_sinc[3];
    bit          m_drop;
    logic [2:0]  m_rdy;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] rt(input int i);
        case (i)
            0:       return in_route_x;
            1:       return in_route_y;
            default: return in_route_local;
        endcase
    endfunction

    function automatic logic [39:0] dat(input int i);
        case (i)
            0:       return in_data_x;
            1:       return in_data_y;
            default: return in_data_local;
        endcase
    endfunction

    task automatic model_reset();
        for (int o = 0; o < 3; o++) begin
            m_ov[o] = 0; m_od[o] = '0; m_ptr[o] = 2; m_stall[o] = 0;
        end
        m_err = 0;
    endtask

    // Decide who wins each output this cycle from the current model state.
    task automatic model_eval();
        int nreq;
        bit free;
        m_rdy  = '0;
        m_drop = 0;
        for (int o = 0; o < 3; o++) begin
            m_win[o] = -1;
            nreq     = 0;
            free     = !m_ov[o] || out_ready[o];
            for (int k = 1; k <= 3; k++) begin
                int i;
                i = (m_ptr[o] + k) % 3;
                if (in_valid[i] && rt(i) == 2'(o + 1)) begin
                    nreq++;
                    if (free && m_win[o] < 0) m_win[o] = i;
                end
            end
            if (m_win[o] >= 0) m_rdy[m_win[o]] = 1'b1;
            m_sinc[o] = nreq > ((m_win[o] >= 0) ? 1 : 0);
        end
        for (int i = 0; i < 3; i++)
            if (in_valid[i] && rt(i) == 2'b00) begin
                m_rdy[i] = 1'b1;
                m_drop   = 1;
            end
    endtask

    task automatic model_commit();
        for (int o = 0; o < 3; o++) begin
            if (m_win[o] >= 0) begin
                m_ov[o]  = 1;
                m_od[o]  = dat(m_win[o]);
                m_ptr[o] = m_win[o];
            end else if (out_ready[o]) begin
                m_ov[o] = 0;
            end
            if (m_sinc[o] && m_stall[o] < 65535) m_stall[o]++;
        end
        m_err = m_drop;
    endtask

    // Inputs are driven at the falling edge; checks sit 1 time unit after each edge.
    task automatic step(input string tag);
        #1;
        model_eval();
        chk({tag, ".in_ready"}, 64'(in_ready), 64'(m_rdy));
        @(posedge clk);
        model_commit();
        #1;
        chk({tag, ".out_valid"}, 64'(out_valid), 64'({m_ov[2], m_ov[1], m_ov[0]}));
        chk({tag, ".out_data_x"}, 64'(out_data_x), 64'(m_od[0]));
        chk({tag, ".out_data_y"}, 64'(out_data_y), 64'(m_od[1]));
        chk({tag, ".out_data_local"}, 64'(out_data_local), 64'(m_od[2]));
        chk({tag, ".err_route"}, 64'(err_route), 64'(m_err));
`ifdef ROUTER_ALLOC_STALL_CNT_EN
        chk({tag, ".stall_x"}, 64'(stall_cnt_x), 64'(m_stall[0]));
        chk({tag, ".stall_y"}, 64'(stall_cnt_y), 64'(m_stall[1]));
        chk({tag, ".stall_l"}, 64'(stall_cnt_local), 64'(m_stall[2]));
`endif
        @(negedge clk);
    endtask

    logic [39:0] cd[3];
    logic [39:0] d1, d2;

    initial begin
        model_reset();

        // Reset: requests present but nothing accepted while rst is high
        in_valid = 3'b111;
        in_route_x = 2'b01; in_route_y = 2'b01; in_route_local = 2'b01;
        out_ready = 3'b111;
        #3;
        chk("rst.in_ready", 64'(in_ready), 64'd0);
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.out_data_x", 64'(out_data_x), 64'd0);
        chk("rst.err_route", 64'(err_route), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst.first_grant", 64'(in_ready), 64'(3'b001));
        step("rel");

        // Single flit to local output
        in_valid = 3'b001; in_data_x = 40'h12_3456_789A; in_route_x = 2'b11;
        #1;
        chk("single.in_ready", 64'(in_ready), 64'(3'b001));
        step("single");
        chk("single.out_valid_l", 64'(out_valid[2]), 64'd1);
        chk("single.out_data_l", 64'(out_data_local), 64'h12_3456_789A);

        // Contention: three inputs to Y, served X, Y, Local
        cd[0] = 40'hA0_0000_0001; cd[1] = 40'hB0_0000_0002; cd[2] = 40'hC0_0000_0003;
        in_valid = 3'b111;
        in_route_x = 2'b10; in_route_y = 2'b10; in_route_local = 2'b10;
        in_data_x = cd[0]; in_data_y = cd[1]; in_data_local = cd[2];
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("cont.in_ready", 64'(in_ready), 64'(3'b001 << c));
            step("cont");
            chk("cont.out_data_y", 64'(out_data_y), 64'(cd[c]));
            in_valid[c] = 1'b0;
        end
`ifdef ROUTER_ALLOC_STALL_CNT_EN
        chk("cont.stall_y", 64'(stall_cnt_y), 64'd2);
`endif

        // Backpressure on X output
        out_ready = 3'b000;
        d1 = 40'h11_1111_1111; d2 = 40'h22_2222_2222;
        in_valid = 3'b001; in_route_x = 2'b01; in_data_x = d1;
        step("bp.load");
        in_valid = 3'b010; in_route_y = 2'b01; in_data_y = d2;
        #1;
        chk("bp.in_ready_blocked", 64'(in_ready[1]), 64'd0);
        step("bp.hold");
        chk("bp.data_stable", 64'(out_data_x), 64'(d1));
        out_ready = 3'b001;
        #1;
        chk("bp.in_ready_go", 64'(in_ready[1]), 64'd1);
        step("bp.swap");
        chk("bp.out_valid_x", 64'(out_valid[0]), 64'd1);
        chk("bp.out_data_x", 64'(out_data_x), 64'(d2));

        // Invalid route: dropped with a one-cycle error pulse
        out_ready = 3'b000;
        in_valid = 3'b010; in_route_y = 2'b00;
        #1;
        chk("inv.in_ready", 64'(in_ready), 64'(3'b010));
        step("inv");
        chk("inv.err", 64'(err_route), 64'd1);
        in_valid = 3'b000;
        step("inv.after");
        chk("inv.err_clear", 64'(err_route), 64'd0);

        // Mid-operation reset with a full Y output held by backpressure
        out_ready = 3'b111;
        step("mid.drain");
        out_ready = 3'b000;
        in_valid = 3'b010; in_route_y = 2'b10; in_data_y = 40'h33_3333_3333;
        step("mid.load");
        chk("mid.out_valid_pre", 64'(out_valid), 64'(3'b010));
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("mid.out_valid_rst", 64'(out_valid), 64'd0);
        chk("mid.in_ready_rst", 64'(in_ready), 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        in_valid = 3'b000;
        step("mid.post");

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            in_valid       = 3'($urandom);
            in_route_x     = 2'($urandom);
            in_route_y     = 2'($urandom);
            in_route_local = 2'($urandom);
            in_data_x      = {8'($urandom), 32'($urandom)};
            in_data_y      = {8'($urandom), 32'($urandom)};
            in_data_local  = {8'($urandom), 32'($urandom)};
            for (int b = 0; b < 3; b++) out_ready[b] = ($urandom_range(0, 3) != 0);
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
